or4_event_capture: RTL
======================

Name: or4_event_capture

Overview:
- Sequential stage that sits directly downstream of the 4-input OR cell.
- Captures rising edges on four asynchronous event lines (A1..A4, the same operands the OR cell combines) into sticky per-line pending flags.
- Presents a registered OR of the pending flags (Z) as an interrupt/wake request, with an acknowledge handshake, post-acknowledge hold-off and a saturating event counter.
- Used where the bare OR4 output is too glitchy or too transient to be consumed by a clocked controller.

Parameters:
- SYNC_STAGES, 2, synchronizer depth per event input; legal range 2..3.
- HOLDOFF, 4, cycles Z is suppressed after an acknowledged clear; 0 disables the hold-off; legal range 0..255.
- CW, 8, event counter width; legal range 1..16.

Ports:
- CLK  input  1  rising-edge clock.
- RN  input  1  asynchronous active-low reset.
- A1  input  1  event line 1, asynchronous.
- A2  input  1  event line 2, asynchronous.
- A3  input  1  event line 3, asynchronous.
- A4  input  1  event line 4, asynchronous.
- EN  input  4  per-line capture enable; bit0 = A1 … bit3 = A4.
- ACK  input  1  acknowledge, synchronous to CLK.
- CLR  input  4  per-line clear mask, sampled with ACK.
- CCLR  input  1  synchronous counter clear.
- Z  output  1  registered request = OR of pending flags, gated by hold-off.
- PEND  output  4  sticky pending flags.
- CNT  output  CW  saturating count of captured edges.

Behaviour:
- Reset (RN=0, asynchronous): all synchronizer and edge flops, PEND, Z, CNT, hold-off counter and the ACK-edge flop go to 0; state = IDLE. Release is synchronous to CLK.
- Synchronizer: each Ai passes through SYNC_STAGES flops, then one edge flop.
- Edge detection: edge_i = sync_i & ~edge_flop_i.
- Capture latency: an Ai rise sampled at edge n sets PEND at edge n+SYNC_STAGES+1 (n+3 at default).
- Capture: PEND[i] sets on edge_i & EN[i]. Falling edges are ignored. EN=0 blocks new captures but does not clear an existing flag.
- ACK handling: ACK is edge-qualified internally. A clear occurs only in the first cycle ACK is high (ACK & ~ACK_q). Holding ACK high clears once.
- Clear: on a qualified ACK, PEND[i] clears where CLR[i]=1.
- Set/clear collision: a new capture and a clear on the same bit in the same cycle -> set wins; PEND stays 1 and no event is lost.
- Counter: each cycle CNT += popcount of the accepted edges (0..4).
  - Saturates at 2^CW-1; no wrap.
  - CCLR=1 -> CNT = popcount of that cycle's accepted edges.
  - CCLR has priority over accumulation of prior count.
- FSM, registered state:
  - IDLE: Z=0. Next-state PEND != 0 -> ACTIVE.
  - ACTIVE: Z=1.
    - Qualified ACK leaving next PEND == 0 -> HOLD if HOLDOFF>0, else IDLE.
    - Qualified ACK leaving PEND != 0 -> stay ACTIVE.
  - HOLD: Z=0; the hold-off counter loads HOLDOFF-1 on entry and decrements each cycle.
    - Captures during HOLD still set PEND and CNT.
    - At counter 0 -> ACTIVE if PEND != 0, else IDLE.
    - ACK in HOLD still clears PEND; it does not restart the hold-off.
- Z is a flop driven from next-state: Z rises the same edge PEND first becomes non-zero from IDLE, and falls the same edge the clearing ACK is registered.
- All outputs are glitch-free registers; there is no combinational path from any input to any output.
- Reset mid-operation: immediate return to the reset values above; in-flight synchronized edges are discarded.

Test Plan:
- Reset/defaults: RN=0 with A1..A4=1 -> PEND=0, Z=0, CNT=0. Release RN with A1..A4 held high -> edges fire once the synchronizer fills: PEND=4'hF, CNT=4 after 3 cycles.
- Single capture latency: EN=4'hF, pulse A3 high for 1 cycle at edge 10 -> PEND=4'b0100 and Z=1 at edge 13, CNT=1. A3 falling -> no change.
- ACK + hold-off: with PEND=4'b0100, ACK=1 for 5 cycles with CLR=4'b0100 -> PEND=0 and Z=0 after one edge, single clear only. Z stays 0 for 4 cycles. A1 edge during HOLD -> PEND=4'b0001 and Z=1 right after HOLD ends.
- Collision: A2 edge arrives in the same cycle as qualified ACK with CLR=4'b0010 -> PEND[1] remains 1, Z remains 1, CNT increments by 1.
- Saturation/CCLR: CW=2, 5 captured edges -> CNT=3. CCLR coinciding with 2 simultaneous edges -> CNT=2.
- Masking/async reset: EN=4'b0000 with edges on all lines -> PEND=0, CNT=0. Assert RN low mid-HOLD -> everything 0 asynchronously, FSM in IDLE after release.

Source files
------------

// File: rtl/or4_event_capture.sv
// rtl/or4_event_capture.sv - edge capture, sticky pending flags and qualified request downstream of an OR4 cell
// Async inputs are synchronized, rising edges latched per line, and the OR of the flags is issued as a registered request.
module or4_event_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF     = 4,
  parameter int CW          = 8
) (
  input  logic          CLK,
  input  logic          RN,
  input  logic          A1,
  input  logic          A2,
  input  logic          A3,
  input  logic          A4,
  input  logic [3:0]    EN,
  input  logic          ACK,
  input  logic [3:0]    CLR,
  input  logic          CCLR,
  output logic          Z,
  output logic [3:0]    PEND,
  output logic [CW-1:0] CNT
);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

  localparam logic [7:0]    HOLD_LOAD = (HOLDOFF > 0) ? 8'(HOLDOFF - 1) : 8'd0;
  localparam logic [CW+2:0] CNT_MAX   = {3'b000, {CW{1'b1}}};

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]    edge_flop_q, edge_q;
  logic          ack_q;
  logic [3:0]    pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          z_q, z_d;
  logic [7:0]    hold_q, hold_d;
  state_t        state_q, state_d;

  logic [3:0]    sync_out, accepted, clr_mask;
  logic          ack_rise;
  logic [2:0]    n_acc;
  logic [CW-1:0] cnt_base;
  logic [CW+2:0] cnt_sum;

  assign sync_out = sync_q[SYNC_STAGES-1];
  // edge_q adds one register so accepted edges come straight from a flop
  assign accepted = edge_q & EN;
  assign ack_rise = ACK & ~ack_q;
  assign clr_mask = ack_rise ? CLR : 4'b0000;
  // OR-ing the capture after the clear makes set win on a collision
  assign pend_d   = (pend_q & ~clr_mask) | accepted;

  assign n_acc    = {2'b00, accepted[0]} + {2'b00, accepted[1]} +
                    {2'b00, accepted[2]} + {2'b00, accepted[3]};
  assign cnt_base = CCLR ? '0 : cnt_q;
  assign cnt_sum  = {3'b000, cnt_base} + {{CW{1'b0}}, n_acc};
  assign cnt_d    = (cnt_sum > CNT_MAX) ? {CW{1'b1}} : cnt_sum[CW-1:0];

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (pend_d != 4'b0000) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (ack_rise && pend_d == 4'b0000) begin
          if (HOLDOFF > 0) begin
            state_d = HOLD;
            hold_d  = HOLD_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (hold_q == 8'd0) state_d = (pend_d != 4'b0000) ? ACTIVE : IDLE;
        else                hold_d  = hold_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
    z_d = (state_d == ACTIVE);
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sync_q      <= '0;
      edge_flop_q <= 4'b0000;
      edge_q      <= 4'b0000;
      ack_q       <= 1'b0;
      pend_q      <= 4'b0000;
      cnt_q       <= '0;
      z_q         <= 1'b0;
      hold_q      <= 8'd0;
      state_q     <= IDLE;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], {A4, A3, A2, A1}};
      edge_flop_q <= sync_out;
      edge_q      <= sync_out & ~edge_flop_q;
      ack_q       <= ACK;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      z_q         <= z_d;
      hold_q      <= hold_d;
      state_q     <= state_d;
    end
  end

  assign Z    = z_q;
  assign PEND = pend_q;
  assign CNT  = cnt_q;

endmodule
